// File: rtl/sar_search_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sar_search_ctrl_pkg
// Description : Shared types and helpers for the successive-approximation
//               search controller: FSM state encoding, trial-counter width
//               calculation and the comparator-flag one-hot test.
// Revision    : 1.0 - initial release
// ============================================================================
package sar_search_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    FIN  = 2'd2
  } sar_state_t;

  // The search needs up to WIDTH+1 comparisons. The counter must also hold
  // the value WIDTH+1 itself, so size it for WIDTH+2 distinct codes.
  function automatic int calc_cnt_w(input int width);
    return $clog2(width + 2);
  endfunction

  // A healthy comparator asserts exactly one of Greater/Equal/Less.
  function automatic logic flag_onehot(input logic g, input logic e, input logic l);
    return (g & ~e & ~l) | (~g & e & ~l) | (~g & ~e & l);
  endfunction

endpackage : sar_search_ctrl_pkg
`default_nettype wire

// File: rtl/sar_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sar_search_ctrl
// Description : Binary-search controller wrapped around an external
//               combinational magnitude comparator. Drives the comparator B
//               operand with a trial value and narrows a [lo,hi] window from
//               the Greater/Equal/Less result, one comparison per clock.
//
// Ports       : clk     - rising-edge clock
//               rst_n   - asynchronous active-low reset
//               Start   - begin a search (only honoured in IDLE)
//               Abort   - synchronous cancel, back to IDLE without a pulse
//               Greater - comparator flag, A > B
//               Equal   - comparator flag, A == B
//               Less    - comparator flag, A < B
//               B       - registered trial operand to the comparator
//               Busy    - high while a search or its result cycle is active
//               Done    - one-cycle pulse, search found A
//               Error   - one-cycle pulse, search failed
//               Value   - found value, held until the next accepted Start
//               Trials  - comparisons used, held until the next accepted Start
// Revision    : 1.0 - initial release
// ============================================================================
module sar_search_ctrl
  import sar_search_ctrl_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int CNT_W = calc_cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic             Abort,
  input  logic             Greater,
  input  logic             Equal,
  input  logic             Less,
  output logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             Error,
  output logic [WIDTH-1:0] Value,
  output logic [CNT_W-1:0] Trials
);

  // Window bounds carry one extra bit so lo+hi never overflows.
  localparam logic [WIDTH:0]   c_max  = {1'b0, {WIDTH{1'b1}}};
  localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH + 1);

  sar_state_t       r_state, w_state_nx;
  logic [WIDTH-1:0] r_b, w_b_nx;
  logic [WIDTH:0]   r_lo, w_lo_nx;
  logic [WIDTH:0]   r_hi, w_hi_nx;
  logic [WIDTH-1:0] r_value, w_value_nx;
  logic [CNT_W-1:0] r_trials, w_trials_nx;
  logic             r_ok, w_ok_nx;

  logic [WIDTH:0]   w_b_ext;
  logic [WIDTH:0]   w_sum;
  logic [CNT_W-1:0] w_trials_inc;
  logic             w_load_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_b      <= '0;
      r_lo     <= '0;
      r_hi     <= '0;
      r_value  <= '0;
      r_trials <= '0;
      r_ok     <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_b      <= w_b_nx;
      r_lo     <= w_lo_nx;
      r_hi     <= w_hi_nx;
      r_value  <= w_value_nx;
      r_trials <= w_trials_nx;
      r_ok     <= w_ok_nx;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_lo_nx      = r_lo;
    w_hi_nx      = r_hi;
    w_value_nx   = r_value;
    w_trials_nx  = r_trials;
    w_ok_nx      = r_ok;
    w_load_b     = 1'b0;
    w_b_ext      = {1'b0, r_b};
    w_trials_inc = r_trials + 1'b1;

    case (r_state)
      IDLE: begin
        if (Start && !Abort) begin
          w_lo_nx     = '0;
          w_hi_nx     = c_max;
          w_trials_nx = '0;
          w_value_nx  = '0;
          w_ok_nx     = 1'b0;
          w_load_b    = 1'b1;
          w_state_nx  = EVAL;
        end
      end

      EVAL: begin
        if (Abort) begin
          w_state_nx = IDLE;
        end else begin
          w_trials_nx = w_trials_inc;
          w_state_nx  = FIN;
          w_ok_nx     = 1'b0;
          if (!flag_onehot(Greater, Equal, Less)) begin
            w_ok_nx = 1'b0;
          end else if (Equal) begin
            w_ok_nx    = 1'b1;
            w_value_nx = r_b;
          end else if (w_trials_inc == c_last) begin
            w_ok_nx = 1'b0;
          end else if (Greater) begin
            // A above the top of the window means A moved; stop before B+1
            // could step outside the range.
            if (w_b_ext != r_hi) begin
              w_lo_nx    = w_b_ext + 1'b1;
              w_load_b   = 1'b1;
              w_state_nx = EVAL;
            end
          end else begin
            // Same guard on the low side keeps B-1 from wrapping below zero.
            if (w_b_ext != r_lo) begin
              w_hi_nx    = w_b_ext - 1'b1;
              w_load_b   = 1'b1;
              w_state_nx = EVAL;
            end
          end
        end
      end

      FIN: begin
        w_state_nx = IDLE;
      end

      default: begin
        w_state_nx = IDLE;
      end
    endcase

    // Next trial is the midpoint of the window being loaded this cycle.
    w_sum  = w_lo_nx + w_hi_nx;
    w_b_nx = w_load_b ? WIDTH'(w_sum >> 1) : r_b;
  end

  assign B      = r_b;
  assign Value  = r_value;
  assign Trials = r_trials;
  assign Busy   = (r_state != IDLE);
  // Result pulses live in the single FIN cycle; Abort there swallows them.
  assign Done   = (r_state == FIN) &&  r_ok && !Abort;
  assign Error  = (r_state == FIN) && !r_ok && !Abort;

endmodule : sar_search_ctrl
`default_nettype wire

// File: tb/tb_sar_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sar_search_ctrl
// Description : Directed bench for sar_search_ctrl with a behavioural 4-bit
//               magnitude comparator closing the loop. The comparator flags
//               can be overridden to inject illegal flag combinations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sar_search_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [3:0] a;
  logic       ov_en, ov_g, ov_e, ov_l;
  logic       cmp_g, cmp_e, cmp_l;
  logic [3:0] b;
  logic       busy, done, error;
  logic [3:0] value;
  logic [2:0] trials;

  int n_checks = 0;
  int n_errors = 0;

  int exp_up[5]   = '{7, 11, 13, 14, 15};
  int exp_down[4] = '{7, 3, 1, 0};

  // Comparator beside the controller: A is the unknown, B the trial.
  assign cmp_g = ov_en ? ov_g : (a >  b);
  assign cmp_e = ov_en ? ov_e : (a == b);
  assign cmp_l = ov_en ? ov_l : (a <  b);

  sar_search_ctrl #(.WIDTH(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .Start   (start),
    .Abort   (abort),
    .Greater (cmp_g),
    .Equal   (cmp_e),
    .Less    (cmp_l),
    .B       (b),
    .Busy    (busy),
    .Done    (done),
    .Error   (error),
    .Value   (value),
    .Trials  (trials)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    n_checks++; if (b !== 4'd0)      begin n_errors++; $display("FAIL reset_b: got %0d expected 0", b); end
    n_checks++; if (busy !== 1'b0)   begin n_errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    n_checks++; if ({done, error} !== 2'b00) begin n_errors++; $display("FAIL reset_pulses: got %b expected 00", {done, error}); end
    n_checks++; if (value !== 4'd0)  begin n_errors++; $display("FAIL reset_value: got %0d expected 0", value); end
    n_checks++; if (trials !== 3'd0) begin n_errors++; $display("FAIL reset_trials: got %0d expected 0", trials); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_first_hit;
    a = 4'd7;
    pulse_start();
    n_checks++; if (b !== 4'd7)    begin n_errors++; $display("FAIL hit7_b: got %0d expected 7", b); end
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL hit7_busy1: got %0b expected 1", busy); end
    tick();
    n_checks++; if (done !== 1'b1 || error !== 1'b0) begin n_errors++; $display("FAIL hit7_done: got done=%0b err=%0b expected 1/0", done, error); end
    n_checks++; if (value !== 4'd7)  begin n_errors++; $display("FAIL hit7_value: got %0d expected 7", value); end
    n_checks++; if (trials !== 3'd1) begin n_errors++; $display("FAIL hit7_trials: got %0d expected 1", trials); end
    n_checks++; if (busy !== 1'b1)   begin n_errors++; $display("FAIL hit7_busy2: got %0b expected 1", busy); end
    tick();
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_errors++; $display("FAIL hit7_idle: got busy=%0b done=%0b expected 0/0", busy, done); end
  endtask

  // A=15 with Start held high while busy: the sequence must not restart.
  task automatic test_top_start_ignored;
    a = 4'd15;
    pulse_start();
    start = 1'b1;
    n_checks++; if (b !== exp_up[0][3:0]) begin n_errors++; $display("FAIL up_b0: got %0d expected %0d", b, exp_up[0]); end
    for (int k = 1; k < 5; k++) begin
      tick();
      n_checks++; if (b !== exp_up[k][3:0]) begin n_errors++; $display("FAIL up_b%0d: got %0d expected %0d", k, b, exp_up[k]); end
      n_checks++; if (error !== 1'b0)       begin n_errors++; $display("FAIL up_err%0d: got %0b expected 0", k, error); end
    end
    tick();
    start = 1'b0;
    n_checks++; if (done !== 1'b1 || error !== 1'b0) begin n_errors++; $display("FAIL up_done: got done=%0b err=%0b expected 1/0", done, error); end
    n_checks++; if (value !== 4'd15) begin n_errors++; $display("FAIL up_value: got %0d expected 15", value); end
    n_checks++; if (trials !== 3'd5) begin n_errors++; $display("FAIL up_trials: got %0d expected 5", trials); end
    tick();
    n_checks++; if (busy !== 1'b0 || b !== 4'd15) begin n_errors++; $display("FAIL up_hold: got busy=%0b b=%0d expected 0/15", busy, b); end
  endtask

  task automatic test_bottom;
    a = 4'd0;
    pulse_start();
    n_checks++; if (b !== exp_down[0][3:0]) begin n_errors++; $display("FAIL dn_b0: got %0d expected %0d", b, exp_down[0]); end
    for (int k = 1; k < 4; k++) begin
      tick();
      n_checks++; if (b !== exp_down[k][3:0]) begin n_errors++; $display("FAIL dn_b%0d: got %0d expected %0d", k, b, exp_down[k]); end
    end
    tick();
    n_checks++; if (done !== 1'b1 || error !== 1'b0) begin n_errors++; $display("FAIL dn_done: got done=%0b err=%0b expected 1/0", done, error); end
    n_checks++; if (value !== 4'd0)  begin n_errors++; $display("FAIL dn_value: got %0d expected 0", value); end
    n_checks++; if (trials !== 3'd4) begin n_errors++; $display("FAIL dn_trials: got %0d expected 4", trials); end
    tick();
  endtask

  // A moves from 9 to 2 mid-search: window collapses to lo=8 and fails.
  task automatic test_moving_target;
    a = 4'd9;
    pulse_start();
    tick();
    tick();
    a = 4'd2;
    n_checks++; if (b !== 4'd9) begin n_errors++; $display("FAIL mv_b2: got %0d expected 9", b); end
    tick();
    n_checks++; if (b !== 4'd8) begin n_errors++; $display("FAIL mv_b3: got %0d expected 8", b); end
    tick();
    n_checks++; if (error !== 1'b1 || done !== 1'b0) begin n_errors++; $display("FAIL mv_err: got done=%0b err=%0b expected 0/1", done, error); end
    n_checks++; if (value !== 4'd0)  begin n_errors++; $display("FAIL mv_value: got %0d expected 0", value); end
    n_checks++; if (trials !== 3'd4) begin n_errors++; $display("FAIL mv_trials: got %0d expected 4", trials); end
    tick();
    n_checks++; if (busy !== 1'b0 || error !== 1'b0) begin n_errors++; $display("FAIL mv_idle: got busy=%0b err=%0b expected 0/0", busy, error); end
  endtask

  task automatic test_bad_flags;
    a = 4'd7;
    pulse_start();
    ov_en = 1'b1; ov_g = 1'b1; ov_e = 1'b1; ov_l = 1'b0;
    tick();
    n_checks++; if (error !== 1'b1 || done !== 1'b0) begin n_errors++; $display("FAIL flags_err: got done=%0b err=%0b expected 0/1", done, error); end
    n_checks++; if (trials !== 3'd1) begin n_errors++; $display("FAIL flags_trials: got %0d expected 1", trials); end
    ov_en = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL flags_idle: got %0b expected 0", busy); end
  endtask

  task automatic test_abort;
    a = 4'd9;
    pulse_start();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL ab_busy: got %0b expected 0", busy); end
    n_checks++; if ({done, error} !== 2'b00) begin n_errors++; $display("FAIL ab_pulse: got %b expected 00", {done, error}); end
    n_checks++; if (trials !== 3'd1 || b !== 4'd11) begin n_errors++; $display("FAIL ab_hold: got trials=%0d b=%0d expected 1/11", trials, b); end
    pulse_start();
    n_checks++; if (busy !== 1'b1 || b !== 4'd7 || trials !== 3'd0) begin n_errors++; $display("FAIL ab_restart: got busy=%0b b=%0d trials=%0d expected 1/7/0", busy, b, trials); end
    tick();
    tick();
    tick();
    n_checks++; if (done !== 1'b1 || value !== 4'd9 || trials !== 3'd3) begin n_errors++; $display("FAIL ab_done: got done=%0b value=%0d trials=%0d expected 1/9/3", done, value, trials); end
    tick();
  endtask

  task automatic test_reset_mid;
    a = 4'd15;
    pulse_start();
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++; if (b !== 4'd0 || busy !== 1'b0 || trials !== 3'd0) begin n_errors++; $display("FAIL rstmid: got b=%0d busy=%0b trials=%0d expected 0/0/0", b, busy, trials); end
    n_checks++; if ({done, error} !== 2'b00) begin n_errors++; $display("FAIL rstmid_pulse: got %b expected 00", {done, error}); end
    #2;
    rst_n = 1'b1;
    tick();
    n_checks++; if (busy !== 1'b0 || b !== 4'd0) begin n_errors++; $display("FAIL rstmid_after: got busy=%0b b=%0d expected 0/0", busy, b); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; a = 4'd0;
    ov_en = 1'b0; ov_g = 1'b0; ov_e = 1'b0; ov_l = 1'b0;
    test_reset();
    test_first_hit();
    test_top_start_ignored();
    test_bottom();
    test_moving_target();
    test_bad_flags();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_sar_search_ctrl
`default_nettype wire
